// File: rtl/recorder_pkg.sv
// Shared recorder definitions: channel count, DMA timeout default and sequencer state encodings.
package recorder_pkg;
   localparam int NCH     = 6;
   localparam int TIMEOUT = 1024;
   localparam int CH_W    = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      ARM    = 3'd2,
      WAIT   = 3'd3,
      FINISH = 3'd4
   } state_t;
endpackage

// File: rtl/priority_pick.sv
// Combinational lowest-set-bit picker: index of the lowest set request bit, valid when any bit is set.
module priority_pick
   import recorder_pkg::*;
#(
   parameter int N = 6
)(
   input  logic [N-1:0]    i_req,
   output logic [CH_W-1:0] o_idx,
   output logic            o_vld
);
   always_comb begin
      o_idx = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            o_idx = CH_W'(k);
         end
      end
      o_vld = |i_req;
   end
endmodule

// File: rtl/channel_dump_sequencer.sv
// Walks the masked recording channels in index order, starting one DMA transfer per channel
// and reporting a descriptor per completed transfer; a stalled DMA is abandoned after TIMEOUT cycles.
module channel_dump_sequencer
   import recorder_pkg::*;
#(
   parameter int TIMEOUT = recorder_pkg::TIMEOUT,
   parameter int NCH     = recorder_pkg::NCH
)(
   input  logic             adc_clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [NCH-1:0]   chan_mask,
   input  logic [8*NCH-1:0] chan_len,
   output logic [2:0]       active_channel,
   output logic             dma_start,
   input  logic             dma_ready,
   output logic             busy,
   output logic             done,
   output logic             desc_valid,
   output logic [2:0]       desc_chan,
   output logic [7:0]       desc_len,
   output logic [NCH-1:0]   dumped_mask,
   output logic             timeout_err
);
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state, w_state_nxt;
   logic [NCH-1:0]     r_pending, w_pending_nxt;
   logic [8*NCH-1:0]   r_len, w_len_nxt;
   logic [2:0]         r_active, w_active_nxt;
   logic               r_dma_start, w_dma_start_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_desc_vld, w_desc_vld_nxt;
   logic [2:0]         r_desc_chan, w_desc_chan_nxt;
   logic [7:0]         r_desc_len, w_desc_len_nxt;
   logic [NCH-1:0]     r_dumped, w_dumped_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic [CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;

   logic [2:0]         w_pick_idx;
   logic               w_pick_vld;
   logic [7:0]         w_pick_len;
   logic [7:0]         w_act_len;

   priority_pick #(.N(NCH)) u_pick (
      .i_req (r_pending),
      .o_idx (w_pick_idx),
      .o_vld (w_pick_vld)
   );

   assign w_pick_len = r_len[{w_pick_idx, 3'b000} +: 8];
   assign w_act_len  = r_len[{r_active, 3'b000} +: 8];

   always_ff @(posedge adc_clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pending   <= '0;
         r_len       <= '0;
         r_active    <= '0;
         r_dma_start <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_desc_vld  <= 1'b0;
         r_desc_chan <= '0;
         r_desc_len  <= '0;
         r_dumped    <= '0;
         r_timeout   <= 1'b0;
         r_wait_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_len       <= w_len_nxt;
         r_active    <= w_active_nxt;
         r_dma_start <= w_dma_start_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_desc_vld  <= w_desc_vld_nxt;
         r_desc_chan <= w_desc_chan_nxt;
         r_desc_len  <= w_desc_len_nxt;
         r_dumped    <= w_dumped_nxt;
         r_timeout   <= w_timeout_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pending_nxt   = r_pending;
      w_len_nxt       = r_len;
      w_active_nxt    = r_active;
      w_dma_start_nxt = 1'b0;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_desc_vld_nxt  = 1'b0;
      w_desc_chan_nxt = r_desc_chan;
      w_desc_len_nxt  = r_desc_len;
      w_dumped_nxt    = r_dumped;
      w_timeout_nxt   = r_timeout;
      w_wait_cnt_nxt  = r_wait_cnt;

      // Abort wins over everything in flight, including a same-cycle dma_ready.
      if (abort && (r_state == SCAN || r_state == ARM || r_state == WAIT)) begin
         w_state_nxt = FINISH;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  w_pending_nxt = chan_mask;
                  w_len_nxt     = chan_len;
                  w_dumped_nxt  = '0;
                  w_timeout_nxt = 1'b0;
                  w_busy_nxt    = 1'b1;
                  w_state_nxt   = SCAN;
               end
            end
            SCAN: begin
               if (!w_pick_vld) begin
                  w_state_nxt = FINISH;
               end else if (w_pick_len != 8'd0) begin
                  w_active_nxt = w_pick_idx;
                  w_state_nxt  = ARM;
               end else begin
                  w_pending_nxt[w_pick_idx] = 1'b0;
               end
            end
            ARM: begin
               w_dma_start_nxt = 1'b1;
               w_wait_cnt_nxt  = '0;
               w_state_nxt     = WAIT;
            end
            WAIT: begin
               if (dma_ready) begin
                  w_desc_vld_nxt          = 1'b1;
                  w_desc_chan_nxt         = r_active;
                  w_desc_len_nxt          = w_act_len;
                  w_dumped_nxt[r_active]  = 1'b1;
                  w_pending_nxt[r_active] = 1'b0;
                  w_state_nxt             = SCAN;
               end else if (r_wait_cnt == CNT_LAST) begin
                  w_timeout_nxt           = 1'b1;
                  w_pending_nxt[r_active] = 1'b0;
                  w_state_nxt             = SCAN;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 1'b1;
               end
            end
            FINISH: begin
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign active_channel = r_active;
   assign dma_start      = r_dma_start;
   assign busy           = r_busy;
   assign done           = r_done;
   assign desc_valid     = r_desc_vld;
   assign desc_chan      = r_desc_chan;
   assign desc_len       = r_desc_len;
   assign dumped_mask    = r_dumped;
   assign timeout_err    = r_timeout;
endmodule
